byte_word_packer: RTL and testbench
===================================

Name: byte_word_packer

Overview:
- Upstream feeder for the W-bit lane-copy datapath stage: collects a stream of 8-bit bytes into one W-bit word, then presents it on a valid/ready output.
- Byte k of a word lands in bits [8k+7:8k], so the downstream 8-lane unrolled copy sees lane-aligned data.
- Supports early termination (in_last), which zero-pads the remaining lanes and reports the byte count.

Parameters:
- W, 256, output word width; must be a multiple of 8 and at least 16.
- N (localparam), W/8, bytes per word.
- CW (localparam), $clog2(N+1), count width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid && in_ready.
- in_byte  in  8  input data byte.
- in_last  in  1  last byte of a packet; closes the current word early.
- out_valid  out  1  out_word and out_nbytes are valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_word  out  W  packed word; lane k = byte k; unfilled lanes are 0.
- out_nbytes  out  CW  number of valid bytes in out_word, range 1..N.

Behaviour:
- Reset (async assert, sync-release semantics):
  - state=FILL, cnt=0, word register=0.
  - out_valid=0, out_word=0, out_nbytes=0.
  - in_ready=1 immediately after release.
- States: FILL (accumulating, cnt in 0..N-1) and HOLD (complete word presented).
- FILL:
  - in_ready=1.
  - On accept: write in_byte to lane cnt.
  - If cnt==N-1 or in_last: next state HOLD, out_valid=1, out_nbytes=cnt+1.
  - Otherwise: cnt<=cnt+1.
- HOLD:
  - out_valid=1.
  - out_word and out_nbytes are stable until handshake, regardless of out_ready.
  - in_ready=out_ready; this gives combinational pass-through, no bubble.
- HOLD with out_ready=1 and a byte accepted in the same cycle:
  - The word is retired.
  - The new byte is written to lane 0 of a cleared word, and cnt<=1.
  - If that byte has in_last=1, or N==1 does not apply, the state stays HOLD with out_nbytes=1. Otherwise the state goes to FILL.
- HOLD with out_ready=1 and no input byte: word cleared to 0, cnt<=0, state FILL, out_valid=0 next cycle.
- Latency: out_valid asserts on the clock edge that accepts the closing byte, i.e. visible the cycle after acceptance.
- Throughput: 1 byte/clk sustained when out_ready is held high.
- in_last at cnt==N-1 is identical to a normal full word: out_nbytes=N, no extra empty word.
- in_last is ignored unless accompanied by an input handshake. A packet of 0 bytes is impossible; no output is generated.
- Unfilled lanes are always 0. The word register is cleared on every retire, never left stale.
- in_byte and in_last are don't-care when in_valid=0.
- in_ready must not depend on in_valid.
- No combinational path from in_* to out_*; only out_ready reaches in_ready.
- Reset mid-word discards partial data; no output is produced for it.
- cnt never exceeds N-1 in FILL.
- out_nbytes equals 0 only while out_valid=0.

Decomposition:
- Shared package: LANE_W=8, a function computing the count width from W, and the state enum {FILL, HOLD}.
- One natural sub-module: byte_lane_demux (cnt → one-hot lane write-enable, N lanes). It is instantiated once; the rest is a single FSM and datapath.

Test Plan:
- W=32 (N=4), out_ready=1, bytes 0x11,0x22,0x33,0x44 on consecutive clocks → one cycle after the 4th: out_word=0x44332211, out_nbytes=4, out_valid high for one cycle.
- W=32, bytes 0xAA,0xBB with in_last on 0xBB → out_word=0x0000BBAA, out_nbytes=2. The next word starts clean at lane 0.
- W=32, out_ready=0 for 5 cycles after a full word 0x04030201, in_valid held high → in_ready=0 throughout, out_word stable. When out_ready rises, the next byte 0x05 is accepted the same cycle and the next word's lane 0 = 0x05.
- W=256, 64 bytes of value i (i=0..63) back-to-back, out_ready=1 → two words, each lane k = k + 32*(word index). Zero gap cycles on in_ready.
- Assert rst after 2 bytes of a W=32 word → out_valid=0, out_word=0, in_ready=1 immediately. The following 4 bytes 0x01..0x04 produce exactly 0x04030201.
- W=32, single byte 0x7F with in_last, accepted while a previous word retires → out_word=0x0000007F, out_nbytes=1, state stays HOLD.

Source files
------------

// File: rtl/byte_word_packer_pkg.sv
// Shared definitions for the byte-to-word packer: lane width, count sizing and FSM states.
package byte_word_packer_pkg;

  localparam int LANE_W = 8;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Count register must represent 0..N inclusive, where N is the lane count.
  function automatic int cnt_width(input int w);
    return $clog2(w / LANE_W + 1);
  endfunction

endpackage

// File: rtl/byte_word_packer_lane_demux.sv
// Decodes the current lane index into a one-hot per-lane byte write enable.
module byte_lane_demux #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic [CW-1:0] i_sel,
  input  logic          i_en,
  output logic [N-1:0]  o_we
);

  always_comb begin
    o_we = '0;
    for (int k = 0; k < N; k++) begin
      if (i_en && (i_sel == CW'(k))) begin
        o_we[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/byte_word_packer.sv
// Packs a stream of bytes into a W-bit lane-aligned word with early termination on in_last.
module byte_word_packer
  import byte_word_packer_pkg::*;
#(
  parameter  int W  = 256,
  localparam int N  = W / LANE_W,
  localparam int CW = cnt_width(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_byte,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_word,
  output logic [CW-1:0] out_nbytes
);

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_nbytes;
  logic [W-1:0]    r_word;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_retire;
  logic            w_close;
  logic [CW-1:0]   w_lane_sel;
  logic [N-1:0]    w_we;
  logic [W-1:0]    w_next_word;

  // Only out_ready reaches in_ready; a retiring word frees the slot in the same cycle.
  assign w_in_ready = (r_state == FILL) || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_retire   = (r_state == HOLD) && out_ready;
  assign w_close    = (r_cnt == CW'(N - 1)) || in_last;
  assign w_lane_sel = (r_state == HOLD) ? '0 : r_cnt;

  byte_lane_demux #(
    .N  (N),
    .CW (CW)
  ) u_lane_demux (
    .i_sel (w_lane_sel),
    .i_en  (w_accept),
    .o_we  (w_we)
  );

  // A retire clears every lane so the next word never carries stale bytes.
  for (genvar k = 0; k < N; k++) begin : g_lane
    assign w_next_word[LANE_W*k +: LANE_W] =
      w_we[k]  ? in_byte :
      w_retire ? 8'h00   : r_word[LANE_W*k +: LANE_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FILL;
      r_cnt    <= '0;
      r_nbytes <= '0;
      r_word   <= '0;
    end else begin
      r_word <= w_next_word;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (w_close) begin
              r_state  <= HOLD;
              r_nbytes <= r_cnt + CW'(1);
              r_cnt    <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          // A single-byte packet arriving during retire goes straight back to HOLD.
          if (out_ready) begin
            if (w_accept && in_last) begin
              r_nbytes <= CW'(1);
              r_cnt    <= '0;
            end else if (w_accept) begin
              r_state  <= FILL;
              r_cnt    <= CW'(1);
              r_nbytes <= '0;
            end else begin
              r_state  <= FILL;
              r_cnt    <= '0;
              r_nbytes <= '0;
            end
          end
        end
        default: begin
          r_state  <= FILL;
          r_cnt    <= '0;
          r_nbytes <= '0;
        end
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = (r_state == HOLD);
  assign out_word   = r_word;
  assign out_nbytes = r_nbytes;

endmodule

// File: tb/tb_byte_word_packer.sv
// Self-checking bench: directed scenarios plus random traffic scored against a packet-level model.
module tb_byte_word_packer;

  typedef struct {
    logic [255:0] word;
    int           nbytes;
  } expEntry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        inValid = 1'b0;
  logic        inReady;
  logic [7:0]  inByte = 8'h00;
  logic        inLast = 1'b0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] outWord;
  logic [2:0]  outNbytes;

  logic         bigInValid = 1'b0;
  logic         bigInReady;
  logic [7:0]   bigInByte = 8'h00;
  logic         bigInLast = 1'b0;
  logic         bigOutValid;
  logic         bigOutReady = 1'b1;
  logic [255:0] bigOutWord;
  logic [5:0]   bigOutNbytes;

  int checkCount = 0;
  int errorCount = 0;

  expEntry_t  expQ[$];
  logic [7:0] curBytes[$];
  logic       expectValid = 1'b0;
  logic       prevStall = 1'b0;
  logic [31:0] prevWord;
  logic [2:0]  prevN;

  always #5 clk = ~clk;

  byte_word_packer #(.W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_byte    (inByte),
    .in_last    (inLast),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_word   (outWord),
    .out_nbytes (outNbytes)
  );

  byte_word_packer #(.W(256)) dutBig (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (bigInValid),
    .in_ready   (bigInReady),
    .in_byte    (bigInByte),
    .in_last    (bigInLast),
    .out_valid  (bigOutValid),
    .out_ready  (bigOutReady),
    .out_word   (bigOutWord),
    .out_nbytes (bigOutNbytes)
  );

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus on the W=32 instance; the model works on whole packets of bytes.
  task automatic applyStimulus(input logic v, input logic [7:0] b, input logic last, input logic ordy);
    logic         accIn;
    logic         accOut;
    expEntry_t    e;
    logic [255:0] w;
    inValid  = v;
    inByte   = b;
    inLast   = last;
    outReady = ordy;
    @(negedge clk);
    if (expectValid) begin
      checkOutput("latency", outValid, 1);
      expectValid = 1'b0;
    end
    if (prevStall) begin
      checkOutput("hold_word", outWord, prevWord);
      checkOutput("hold_nbytes", outNbytes, prevN);
    end
    checkOutput("valid_pending", outValid, expQ.size() > 0);
    checkOutput("in_ready", inReady, !outValid || outReady);
    if (!outValid) checkOutput("idle_nbytes", outNbytes, 0);
    accIn  = inValid && inReady;
    accOut = outValid && outReady;
    if (accOut) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_word", outValid, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("word", outWord, e.word);
        checkOutput("nbytes", outNbytes, e.nbytes);
      end
    end
    prevStall = outValid && !outReady;
    prevWord  = outWord;
    prevN     = outNbytes;
    if (accIn) begin
      curBytes.push_back(b);
      if (curBytes.size() == 4 || last) begin
        w = '0;
        foreach (curBytes[i]) w[8*i +: 8] = curBytes[i];
        e.word   = w;
        e.nbytes = curBytes.size();
        expQ.push_back(e);
        curBytes.delete();
        expectValid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    inValid = 1'b0;
    rst     = 1'b1;
    #1;
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_word", outWord, 0);
    checkOutput("rst_nbytes", outNbytes, 0);
    checkOutput("rst_ready", inReady, 1);
    curBytes.delete();
    expQ.delete();
    prevStall   = 1'b0;
    expectValid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [255:0] bigExp;

    applyReset();

    // Full word with out_ready high
    applyStimulus(1, 8'h11, 0, 1);
    applyStimulus(1, 8'h22, 0, 1);
    applyStimulus(1, 8'h33, 0, 1);
    applyStimulus(1, 8'h44, 0, 1);
    checkOutput("t1_word", outWord, 32'h44332211);
    checkOutput("t1_nbytes", outNbytes, 4);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("t1_valid_drop", outValid, 0);

    // Early termination pads with zeros
    applyStimulus(1, 8'hAA, 0, 1);
    applyStimulus(1, 8'hBB, 1, 1);
    checkOutput("t2_word", outWord, 32'h0000BBAA);
    checkOutput("t2_nbytes", outNbytes, 2);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("t2_clean", outWord, 0);

    // Backpressure then pass-through acceptance on release
    applyStimulus(1, 8'h01, 0, 1);
    applyStimulus(1, 8'h02, 0, 1);
    applyStimulus(1, 8'h03, 0, 1);
    applyStimulus(1, 8'h04, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'h05, 0, 0);
      checkOutput("t3_stall_ready", inReady, 0);
      checkOutput("t3_stall_word", outWord, 32'h04030201);
    end
    applyStimulus(1, 8'h05, 0, 1);
    checkOutput("t3_lane0", outWord, 32'h00000005);
    checkOutput("t3_valid", outValid, 0);
    applyStimulus(1, 8'h06, 0, 1);
    applyStimulus(1, 8'h07, 0, 1);
    applyStimulus(1, 8'h08, 0, 1);
    checkOutput("t3_word2", outWord, 32'h08070605);
    applyStimulus(0, 8'h00, 0, 1);

    // Reset mid-word discards the partial word
    applyStimulus(1, 8'hE1, 0, 1);
    applyStimulus(1, 8'hE2, 0, 1);
    applyReset();
    applyStimulus(1, 8'h01, 0, 1);
    applyStimulus(1, 8'h02, 0, 1);
    applyStimulus(1, 8'h03, 0, 1);
    applyStimulus(1, 8'h04, 0, 1);
    checkOutput("t4_word", outWord, 32'h04030201);
    checkOutput("t4_nbytes", outNbytes, 4);

    // Single-byte packet accepted while the previous word retires
    applyStimulus(1, 8'h7F, 1, 1);
    checkOutput("t5_valid", outValid, 1);
    checkOutput("t5_word", outWord, 32'h0000007F);
    checkOutput("t5_nbytes", outNbytes, 1);
    applyStimulus(0, 8'h00, 0, 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 0, 1);
    checkOutput("drain_empty", expQ.size(), 0);

    // W=256: 64 back-to-back bytes form two words
    for (int i = 0; i < 64; i++) begin
      bigInValid = 1'b1;
      bigInByte  = 8'(i);
      bigInLast  = 1'b0;
      @(negedge clk);
      checkOutput("big_ready", bigInReady, 1);
      if (i == 32) begin
        bigExp = '0;
        for (int k = 0; k < 32; k++) bigExp[8*k +: 8] = 8'(k);
        checkOutput("big_valid0", bigOutValid, 1);
        checkOutput("big_word0", bigOutWord, bigExp);
        checkOutput("big_nbytes0", bigOutNbytes, 32);
      end
      @(posedge clk);
      #1;
    end
    bigInValid = 1'b0;
    @(negedge clk);
    bigExp = '0;
    for (int k = 0; k < 32; k++) bigExp[8*k +: 8] = 8'(k + 32);
    checkOutput("big_valid1", bigOutValid, 1);
    checkOutput("big_word1", bigOutWord, bigExp);
    checkOutput("big_nbytes1", bigOutNbytes, 32);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("big_idle", bigOutValid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
